// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2^2 butterfly front end: default geometry,
// lane-vector type and the pair-buffer FSM state encoding.
package fft_pkg;

  // Default geometry; modules take these as parameter defaults.
  localparam int unsigned FftWidth      = 9;   // signed bits per I or Q lane
  localparam int unsigned FftLanes      = 16;  // lanes per beat
  localparam int unsigned FftHalfBlocks = 16;  // beats per half-frame

  // All lanes of one component (R or Q) packed flat, lane j at bits [j*W +: W].
  typedef logic [FftLanes*FftWidth-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StPair
  } bf2i_state_e;

endpackage

// File: rtl/bf2i_delay_line.sv
// Enabled shift register of Depth words; q_o is the word written Depth enables ago.
module bf2i_delay_line
  import fft_pkg::*;
#(
  parameter int unsigned DataW = 2 * FftLanes * FftWidth,
  parameter int unsigned Depth = FftHalfBlocks
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DataW-1:0] d_i,
  output logic [DataW-1:0] q_o
);

  logic [DataW-1:0] mem_q [Depth];

  // Shift one position per enabled cycle; reset clears every entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q_o = mem_q[Depth-1];

endmodule

// File: rtl/bf2i_pair_buffer.sv
// Pairs x[n] with x[n+N/2] for the first butterfly stage: the first half-frame
// is parked in a delay line, and each second-half beat is emitted alongside
// the beat HALF_BLOCKS valid beats older.
module bf2i_pair_buffer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH       = FftWidth,
  parameter int unsigned LANES       = FftLanes,
  parameter int unsigned HALF_BLOCKS = FftHalfBlocks
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_valid,
  input  logic                           din_sync,
  input  logic [LANES*WIDTH-1:0]         din_R,
  input  logic [LANES*WIDTH-1:0]         din_Q,
  output logic                           dout_valid,
  output logic [LANES*WIDTH-1:0]         dout_R1,
  output logic [LANES*WIDTH-1:0]         dout_Q1,
  output logic [LANES*WIDTH-1:0]         dout_R2,
  output logic [LANES*WIDTH-1:0]         dout_Q2,
  output logic [$clog2(HALF_BLOCKS)-1:0] pair_idx,
  output logic                           sync_err
);

  localparam int unsigned VecW = LANES * WIDTH;
  localparam int unsigned IdxW = $clog2(HALF_BLOCKS);
  localparam int unsigned CntW = $clog2(2 * HALF_BLOCKS);
  localparam logic [CntW-1:0] LastFill = CntW'(HALF_BLOCKS - 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(2 * HALF_BLOCKS - 1);
  localparam logic [CntW-1:0] HalfCnt  = CntW'(HALF_BLOCKS);

  bf2i_state_e     state_q, state_d;
  // Frame index of the next beat to be accepted.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            shift_en, pair_en, err_d;
  logic [2*VecW-1:0] line_out;

  logic            valid_q, err_q;
  logic [VecW-1:0] r1_q, q1_q, r2_q, q2_q;
  logic [IdxW-1:0] idx_q;

  bf2i_delay_line #(
    .DataW (2 * VecW),
    .Depth (HALF_BLOCKS)
  ) u_line (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (shift_en),
    .d_i   ({din_R, din_Q}),
    .q_o   (line_out)
  );

  // Next state, beat counter and per-beat actions for the accepted beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    pair_en  = 1'b0;
    err_d    = 1'b0;
    if (din_valid) begin
      if (din_sync) begin
        // Sync always starts a new frame; only a mid-frame restart is an error.
        shift_en = 1'b1;
        state_d  = StFill;
        cnt_d    = CntW'(1);
        err_d    = (state_q != StIdle) && (cnt_q != '0);
      end else if (state_q != StIdle) begin
        shift_en = 1'b1;
        cnt_d    = (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
        if (state_q == StFill && cnt_q == LastFill) state_d = StPair;
        if (state_q == StPair) begin
          pair_en = 1'b1;
          // Last beat rolls straight into the next frame's fill phase.
          if (cnt_q == LastBeat) state_d = StFill;
        end
      end
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers: data hold their last pair while no pair is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      r1_q    <= '0;
      q1_q    <= '0;
      r2_q    <= '0;
      q2_q    <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= pair_en;
      err_q   <= err_d;
      if (pair_en) begin
        r1_q  <= line_out[2*VecW-1:VecW];
        q1_q  <= line_out[VecW-1:0];
        r2_q  <= din_R;
        q2_q  <= din_Q;
        idx_q <= IdxW'(cnt_q - HalfCnt);
      end
    end
  end

  assign dout_valid = valid_q;
  assign sync_err   = err_q;
  assign dout_R1    = r1_q;
  assign dout_Q1    = q1_q;
  assign dout_R2    = r2_q;
  assign dout_Q2    = q2_q;
  assign pair_idx   = idx_q;

endmodule

// File: tb/tb_bf2i_pair_buffer.sv
// Bench for bf2i_pair_buffer: directed scenarios plus random traffic, checked
// every cycle against a frame-list reference model.
module tb_bf2i_pair_buffer;

  localparam int W  = 9;
  localparam int L  = 16;
  localparam int HB = 16;
  localparam int VW = W * L;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_valid, din_sync;
  logic [VW-1:0] din_R, din_Q;
  logic          dout_valid, sync_err;
  logic [VW-1:0] dout_R1, dout_Q1, dout_R2, dout_Q2;
  logic [3:0]    pair_idx;

  bf2i_pair_buffer #(
    .WIDTH       (W),
    .LANES       (L),
    .HALF_BLOCKS (HB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_sync   (din_sync),
    .din_R      (din_R),
    .din_Q      (din_Q),
    .dout_valid (dout_valid),
    .dout_R1    (dout_R1),
    .dout_Q1    (dout_Q1),
    .dout_R2    (dout_R2),
    .dout_Q2    (dout_Q2),
    .pair_idx   (pair_idx),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: beats of the current frame in arrival order.
  bit            in_frame = 1'b0;
  logic [VW-1:0] fr_r[$];
  logic [VW-1:0] fr_q[$];
  logic [VW-1:0] exp_r1 = '0, exp_q1 = '0, exp_r2 = '0, exp_q2 = '0;
  logic [3:0]    exp_idx = '0;
  int            n_pairs = 0, n_errs = 0;

  task automatic check_outs(input bit ev, input bit ee, input string ctx);
    check_eq({ctx, " dout_valid"}, VW'(dout_valid), VW'(ev));
    check_eq({ctx, " sync_err"}, VW'(sync_err), VW'(ee));
    check_eq({ctx, " R1"}, dout_R1, exp_r1);
    check_eq({ctx, " Q1"}, dout_Q1, exp_q1);
    check_eq({ctx, " R2"}, dout_R2, exp_r2);
    check_eq({ctx, " Q2"}, dout_Q2, exp_q2);
    check_eq({ctx, " pair_idx"}, VW'(pair_idx), VW'(exp_idx));
  endtask

  task automatic beat(input bit v, input bit s, input logic [VW-1:0] r, input logic [VW-1:0] q,
                      input string ctx);
    bit ev = 1'b0;
    bit ee = 1'b0;
    int pos;
    @(negedge clk);
    din_valid = v;
    din_sync  = s;
    din_R     = r;
    din_Q     = q;
    if (v) begin
      if (s) begin
        ee = in_frame && (fr_r.size() != 0);
        in_frame = 1'b1;
        fr_r.delete();
        fr_q.delete();
        fr_r.push_back(r);
        fr_q.push_back(q);
      end else if (in_frame) begin
        fr_r.push_back(r);
        fr_q.push_back(q);
        pos = fr_r.size() - 1;
        if (pos >= HB) begin
          ev      = 1'b1;
          exp_r1  = fr_r[pos-HB];
          exp_q1  = fr_q[pos-HB];
          exp_r2  = r;
          exp_q2  = q;
          exp_idx = 4'(pos - HB);
        end
        if (fr_r.size() == 2 * HB) begin
          fr_r.delete();
          fr_q.delete();
        end
      end
    end
    if (ev) n_pairs++;
    if (ee) n_errs++;
    @(posedge clk);
    #1;
    check_outs(ev, ee, ctx);
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    fr_r.delete();
    fr_q.delete();
    exp_r1 = '0; exp_q1 = '0; exp_r2 = '0; exp_q2 = '0;
    exp_idx = '0;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic reset_now(input string ctx);
    @(negedge clk);
    din_valid = 1'b0;
    din_sync  = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_outs(1'b0, 1'b0, ctx);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [VW-1:0] ramp(input int b, input bit neg);
    logic [VW-1:0] vec;
    int v;
    for (int j = 0; j < L; j++) begin
      v = b * 16 + j;
      if (neg) v = -v;
      vec[j*W +: W] = W'(v);
    end
    return vec;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] vec;
    for (int j = 0; j < L; j++) vec[j*W +: W] = W'($urandom);
    return vec;
  endfunction

  function automatic logic [VW-1:0] extreme(input bit flip);
    logic [VW-1:0] vec;
    for (int j = 0; j < L; j++) vec[j*W +: W] = ((j % 2 == 0) ^ flip) ? 9'h100 : 9'h0ff;
    return vec;
  endfunction

  int p0, e0;

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din_sync  = 1'b0;
    din_R     = '0;
    din_Q     = '0;
    #1 check_outs(1'b0, 1'b0, "reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Valid beats before any sync are discarded.
    for (int b = 0; b < 4; b++) beat(1'b1, 1'b0, ramp(b, 0), ramp(b, 1), "pre-sync");

    // Continuous frame.
    p0 = n_pairs;
    for (int b = 0; b < 2 * HB; b++) beat(1'b1, b == 0, ramp(b, 0), ramp(b, 1), "cont");
    check_eq("cont pair count", VW'(n_pairs - p0), VW'(HB));

    // Same frame with a gap after every beat.
    for (int b = 0; b < 2 * HB; b++) begin
      beat(1'b1, b == 0, ramp(b, 0), ramp(b, 1), "gaps");
      beat(1'b0, 1'b0, rand_vec(), rand_vec(), "gaps idle");
    end

    // Two back-to-back frames; sync on beat 32 is legal.
    p0 = n_pairs;
    e0 = n_errs;
    for (int b = 0; b < 4 * HB; b++)
      beat(1'b1, (b % (2 * HB)) == 0, ramp(b, 0), ramp(b, 1), "b2b");
    check_eq("b2b pair count", VW'(n_pairs - p0), VW'(2 * HB));
    check_eq("b2b err count", VW'(n_errs - e0), VW'(0));

    // Early sync at beat 20.
    e0 = n_errs;
    for (int b = 0; b < 20; b++) beat(1'b1, b == 0, ramp(b, 0), ramp(b, 1), "early pre");
    p0 = n_pairs;
    for (int b = 0; b < 2 * HB; b++) beat(1'b1, b == 0, ramp(b + 3, 0), ramp(b, 1), "early");
    check_eq("early err count", VW'(n_errs - e0), VW'(1));
    check_eq("early pair count", VW'(n_pairs - p0), VW'(HB));

    // Reset at beat 24, then unsynced beats are ignored.
    for (int b = 0; b < 24; b++) beat(1'b1, b == 0, ramp(b, 0), ramp(b, 1), "pre-rst");
    reset_now("mid-rst");
    p0 = n_pairs;
    for (int b = 0; b < 20; b++) beat(1'b1, 1'b0, ramp(b, 0), ramp(b, 1), "post-rst");
    check_eq("post-rst pair count", VW'(n_pairs - p0), VW'(0));

    // Extreme lane values.
    for (int b = 0; b < 2 * HB; b++)
      beat(1'b1, b == 0, extreme(b[0]), extreme(!b[0]), "extreme");

    // Random traffic with occasional syncs.
    beat(1'b1, 1'b1, rand_vec(), rand_vec(), "rand");
    for (int i = 0; i < 600; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 49) == 0);
      beat(v, s, rand_vec(), rand_vec(), "rand");
    end
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, '0, '0, "tail");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
